temporizador_regressivo_m: RTL and testbench

//  Loadable down-counting timer: the consumer-side counterpart of the modulo-M up counter.
//  - Loads a count from the control unit and decrements it on each 'conta' enable.
//  - Signals terminal count (fim) and half-way (meio) to the drone simulator FSMs.
//  - Used for run-time-programmable delays, where a fixed-M up counter cannot serve.

---
 rtl/temporizador_pkg.sv | 10 +
 rtl/temporizador_regressivo_m.sv | 89 ++++++++
 tb/tb_temporizador_regressivo_m.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/temporizador_pkg.sv
// Shared definitions for the loadable down-counting timer: state encodings and default width.
package temporizador_pkg;

    localparam int unsigned TEMP_N_DEFAULT = 10;

    localparam logic [1:0] ST_OCIOSO   = 2'b00;
    localparam logic [1:0] ST_CONTANDO = 2'b01;
    localparam logic [1:0] ST_FIM      = 2'b10;

endpackage

// File: rtl/temporizador_regressivo_m.sv
// Loadable down-counting timer with terminal-count (fim) and half-way (meio) flags.
// Optional feature: define TEMPORIZADOR_AUTO_RECARGA_EN to reload carga_reg after each FIM.
module temporizador_regressivo_m
    import temporizador_pkg::*;
#(
    parameter int unsigned N = TEMP_N_DEFAULT
) (
    input  logic         clock,
    input  logic         zera_as_n,
    input  logic         zera_s,
    input  logic         carrega,
    input  logic [N-1:0] valor,
    input  logic         conta,
    output logic [N-1:0] Q,
    output logic         fim,
    output logic         meio,
    output logic         ocupado
);

    localparam logic [N-1:0] UM   = N'(1);
    localparam logic [N-1:0] DOIS = N'(2);

    logic [N-1:0] q_q, q_d;
    logic [N-1:0] carga_q, carga_d;
    logic [1:0]   estado_q, estado_d;

    always_comb begin
        q_d      = q_q;
        carga_d  = carga_q;
        estado_d = estado_q;
        if (zera_s) begin
            q_d      = '0;
            carga_d  = '0;
            estado_d = ST_OCIOSO;
        end else if (carrega) begin
            q_d      = valor;
            carga_d  = valor;
            estado_d = (valor != '0) ? ST_CONTANDO : ST_FIM;
        end else begin
            case (estado_q)
                ST_OCIOSO: ;
                ST_CONTANDO: begin
                    if (conta) begin
                        // Q<=1 also catches a stray 0 so the count can never wrap.
                        if (q_q > UM) begin
                            q_d = q_q - UM;
                        end else begin
                            q_d      = '0;
                            estado_d = ST_FIM;
                        end
                    end
                end
                ST_FIM: begin
`ifdef TEMPORIZADOR_AUTO_RECARGA_EN
                    if (carga_q != '0) begin
                        q_d      = carga_q;
                        estado_d = ST_CONTANDO;
                    end else begin
                        q_d      = '0;
                        estado_d = ST_OCIOSO;
                    end
`else
                    q_d      = '0;
                    estado_d = ST_OCIOSO;
`endif
                end
                default: estado_d = ST_OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            q_q      <= '0;
            carga_q  <= '0;
            estado_q <= ST_OCIOSO;
        end else begin
            q_q      <= q_d;
            carga_q  <= carga_d;
            estado_q <= estado_d;
        end
    end

    assign Q       = q_q;
    assign fim     = (estado_q == ST_FIM);
    assign meio    = (estado_q == ST_CONTANDO) && (carga_q >= DOIS) && (q_q == (carga_q >> 1));
    assign ocupado = (estado_q != ST_OCIOSO);

endmodule

// File: tb/tb_temporizador_regressivo_m.sv
// Directed self-checking bench for temporizador_regressivo_m.
module tb_temporizador_regressivo_m;

    localparam int N = 10;

    logic         clock;
    logic         zera_as_n;
    logic         zera_s;
    logic         carrega;
    logic [N-1:0] valor;
    logic         conta;
    logic [N-1:0] Q;
    logic         fim;
    logic         meio;
    logic         ocupado;

    int checks   = 0;
    int failures = 0;

    temporizador_regressivo_m #(.N(N)) dut (
        .clock     (clock),
        .zera_as_n (zera_as_n),
        .zera_s    (zera_s),
        .carrega   (carrega),
        .valor     (valor),
        .conta     (conta),
        .Q         (Q),
        .fim       (fim),
        .meio      (meio),
        .ocupado   (ocupado)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [N-1:0] v);
        carrega = 1'b1;
        valor   = v;
        tick();
        carrega = 1'b0;
    endtask

    task automatic test_reset;
        zera_as_n = 1'b0;
        zera_s    = 1'b0;
        carrega   = 1'b0;
        valor     = '0;
        conta     = 1'b0;
        #2;
        checks++;
        if (Q !== '0 || fim !== 1'b0 || meio !== 1'b0 || ocupado !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: Q=%0d fim=%b meio=%b ocupado=%b, required 0 0 0 0", Q, fim, meio, ocupado);
        end
        #10;
        zera_as_n = 1'b1;
        tick();
    endtask

    task automatic test_async_reset;
        load(7);
        conta = 1'b1;
        repeat (3) tick();
        conta = 1'b0;
        checks++;
        if (Q !== 10'd4 || ocupado !== 1'b1) begin
            failures++;
            $display("FAIL async_pre: Q=%0d ocupado=%b, required Q=4 ocupado=1", Q, ocupado);
        end
        #3 zera_as_n = 1'b0;
        #1;
        checks++;
        if (Q !== '0 || fim !== 1'b0 || meio !== 1'b0 || ocupado !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: Q=%0d fim=%b meio=%b ocupado=%b, required 0 0 0 0", Q, fim, meio, ocupado);
        end
        #2 zera_as_n = 1'b1;
        tick();
        checks++;
        if (fim !== 1'b0 || ocupado !== 1'b0) begin
            failures++;
            $display("FAIL async_no_fim: fim=%b ocupado=%b, required 0 0", fim, ocupado);
        end
    endtask

    task automatic test_continuous;
        logic [N-1:0] exp_q [6];
        exp_q = '{10'd5, 10'd4, 10'd3, 10'd2, 10'd1, 10'd0};
        conta = 1'b1;
        load(5);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (Q !== exp_q[i]) begin
                failures++;
                $display("FAIL cont_q[%0d]: Q=%0d, required %0d", i, Q, exp_q[i]);
            end
            checks++;
            if (meio !== (i == 3)) begin
                failures++;
                $display("FAIL cont_meio[%0d]: meio=%b, required %b", i, meio, (i == 3));
            end
            checks++;
            if (fim !== (i == 5) || ocupado !== 1'b1) begin
                failures++;
                $display("FAIL cont_fim[%0d]: fim=%b ocupado=%b, required %b 1", i, fim, ocupado, (i == 5));
            end
            if (i < 5) tick();
        end
`ifndef TEMPORIZADOR_AUTO_RECARGA_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (Q !== '0 || fim !== 1'b0 || ocupado !== 1'b0) begin
                failures++;
                $display("FAIL cont_after[%0d]: Q=%0d fim=%b ocupado=%b, required 0 0 0", i, Q, fim, ocupado);
            end
        end
`endif
        conta = 1'b0;
        zera_s = 1'b1;
        tick();
        zera_s = 1'b0;
    endtask

    task automatic test_pattern;
        logic       pat   [5];
        logic [N-1:0] exp_q [5];
        pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_q = '{10'd2, 10'd2, 10'd2, 10'd1, 10'd0};
        load(3);
        checks++;
        if (Q !== 10'd3 || fim !== 1'b0) begin
            failures++;
            $display("FAIL pat_load: Q=%0d fim=%b, required 3 0", Q, fim);
        end
        for (int i = 0; i < 5; i++) begin
            conta = pat[i];
            tick();
            checks++;
            if (Q !== exp_q[i]) begin
                failures++;
                $display("FAIL pat_q[%0d]: Q=%0d, required %0d", i, Q, exp_q[i]);
            end
            checks++;
            if (fim !== (i == 4) || meio !== (i == 3)) begin
                failures++;
                $display("FAIL pat_flags[%0d]: fim=%b meio=%b, required %b %b", i, fim, meio, (i == 4), (i == 3));
            end
        end
        conta = 1'b0;
        tick();
        checks++;
        if (fim !== 1'b0 || ocupado !== 1'b0) begin
            failures++;
            $display("FAIL pat_end: fim=%b ocupado=%b, required 0 0", fim, ocupado);
        end
    endtask

    task automatic test_load_zero;
        load(0);
        checks++;
        if (Q !== '0 || fim !== 1'b1 || meio !== 1'b0 || ocupado !== 1'b1) begin
            failures++;
            $display("FAIL zero_load: Q=%0d fim=%b meio=%b ocupado=%b, required 0 1 0 1", Q, fim, meio, ocupado);
        end
        tick();
        checks++;
        if (Q !== '0 || fim !== 1'b0 || meio !== 1'b0 || ocupado !== 1'b0) begin
            failures++;
            $display("FAIL zero_after: Q=%0d fim=%b meio=%b ocupado=%b, required 0 0 0 0", Q, fim, meio, ocupado);
        end
    endtask

    task automatic test_reload_and_clear;
        load(7);
        conta = 1'b1;
        repeat (3) tick();
        conta = 1'b0;
        load(9);
        checks++;
        if (Q !== 10'd9 || fim !== 1'b0 || ocupado !== 1'b1) begin
            failures++;
            $display("FAIL reload: Q=%0d fim=%b ocupado=%b, required 9 0 1", Q, fim, ocupado);
        end
        conta = 1'b1;
        tick();
        conta = 1'b0;
        checks++;
        if (Q !== 10'd8) begin
            failures++;
            $display("FAIL reload_dec: Q=%0d, required 8", Q);
        end
        zera_s  = 1'b1;
        carrega = 1'b1;
        valor   = 10'd5;
        tick();
        zera_s  = 1'b0;
        carrega = 1'b0;
        checks++;
        if (Q !== '0 || fim !== 1'b0 || ocupado !== 1'b0) begin
            failures++;
            $display("FAIL zera_s_prio: Q=%0d fim=%b ocupado=%b, required 0 0 0", Q, fim, ocupado);
        end
        conta = 1'b1;
        tick();
        conta = 1'b0;
        checks++;
        if (Q !== '0 || ocupado !== 1'b0) begin
            failures++;
            $display("FAIL idle_ignores_conta: Q=%0d ocupado=%b, required 0 0", Q, ocupado);
        end
    endtask

    task automatic test_load_in_fim;
        conta = 1'b1;
        load(1);
        tick();
        conta = 1'b0;
        checks++;
        if (Q !== '0 || fim !== 1'b1 || meio !== 1'b0) begin
            failures++;
            $display("FAIL fim_cycle: Q=%0d fim=%b meio=%b, required 0 1 0", Q, fim, meio);
        end
        load(2);
        checks++;
        if (Q !== 10'd2 || fim !== 1'b0 || ocupado !== 1'b1) begin
            failures++;
            $display("FAIL load_in_fim: Q=%0d fim=%b ocupado=%b, required 2 0 1", Q, fim, ocupado);
        end
        zera_s = 1'b1;
        tick();
        zera_s = 1'b0;
    endtask

`ifdef TEMPORIZADOR_AUTO_RECARGA_EN
    task automatic test_auto_recarga;
        logic [N-1:0] exp_q [8];
        exp_q = '{10'd3, 10'd2, 10'd1, 10'd0, 10'd3, 10'd2, 10'd1, 10'd0};
        conta = 1'b1;
        load(3);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (Q !== exp_q[i] || fim !== (i % 4 == 3) || ocupado !== 1'b1) begin
                failures++;
                $display("FAIL auto[%0d]: Q=%0d fim=%b ocupado=%b, required %0d %b 1",
                         i, Q, fim, ocupado, exp_q[i], (i % 4 == 3));
            end
            tick();
        end
        zera_s = 1'b1;
        tick();
        zera_s = 1'b0;
        checks++;
        if (Q !== '0 || ocupado !== 1'b0) begin
            failures++;
            $display("FAIL auto_clear: Q=%0d ocupado=%b, required 0 0", Q, ocupado);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (fim !== 1'b0 || ocupado !== 1'b0) begin
                failures++;
                $display("FAIL auto_quiet[%0d]: fim=%b ocupado=%b, required 0 0", i, fim, ocupado);
            end
        end
        conta = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_async_reset();
        test_continuous();
        test_pattern();
        test_load_zero();
        test_reload_and_clear();
        test_load_in_fim();
`ifdef TEMPORIZADOR_AUTO_RECARGA_EN
        test_auto_recarga();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
